// File: rtl/sos_pkg.sv
// Shared definitions for the SHA-256-style bitwise function pipe: mode tags and
// the reference evaluation used by the pipe and the round datapath.
package sos_pkg;

    // Widest word sos_eval handles; callers size-cast their W-bit words to it.
    localparam int SOS_MAX_W = 64;

    typedef enum logic [1:0] {
        SOS_XOR_AND = 2'b00,
        SOS_CH      = 2'b01,
        SOS_MAJ     = 2'b10,
        SOS_PARITY  = 2'b11
    } sos_mode_e;

    function automatic logic [SOS_MAX_W-1:0] sos_eval(
        input sos_mode_e              mode,
        input logic [SOS_MAX_W-1:0]   a,
        input logic [SOS_MAX_W-1:0]   b,
        input logic [SOS_MAX_W-1:0]   c
    );
        logic [SOS_MAX_W-1:0] r;
        r = '0;
        case (mode)
            SOS_XOR_AND: r = (a ^ b) & c;
            SOS_CH:      r = (a & b) ^ (~a & c);
            SOS_MAJ:     r = (a & b) ^ (a & c) ^ (b & c);
            SOS_PARITY:  r = a ^ b ^ c;
            default:     r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sos_stage.sv
// One elastic register stage of sos_pipe: a valid bit plus the {a, b, f, mode}
// payload, loaded whenever the stage advances.
module sos_stage
    import sos_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          adv,
    input  logic          load_valid,
    input  logic [W-1:0]  load_a,
    input  logic [W-1:0]  load_b,
    input  logic [W-1:0]  load_f,
    input  sos_mode_e     load_mode,
    output logic          valid,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [W-1:0]  f,
    output sos_mode_e     mode
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= load_valid;
        end
    end

    // Payload only moves with a real entry, so a drained output keeps its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a    <= '0;
            b    <= '0;
            f    <= '0;
            mode <= SOS_XOR_AND;
        end else if (adv && load_valid) begin
            a    <= load_a;
            b    <= load_b;
            f    <= load_f;
            mode <= load_mode;
        end
    end

endmodule

// File: rtl/sos_pipe.sv
// Elastic DEPTH-stage pipe that evaluates one of four SHA-256-style bitwise
// functions on an accepted (a, b, c) triple and delivers {a, b, f, mode} in order.
module sos_pipe
    import sos_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_mode,
    input  logic [W-1:0]   Ai,
    input  logic [W-1:0]   Bi,
    input  logic [W-1:0]   Ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   Ao,
    output logic [W-1:0]   Bo,
    output logic [W-1:0]   Fo,
    output logic [1:0]     Mo,
    output logic [CW-1:0]  count
);

    logic [DEPTH-1:0] vld_s;
    logic [DEPTH-1:0] adv;
    logic [W-1:0]     a_s   [DEPTH];
    logic [W-1:0]     b_s   [DEPTH];
    logic [W-1:0]     f_s   [DEPTH];
    sos_mode_e        m_s   [DEPTH];

    logic [DEPTH-1:0] ld_vld;
    logic [W-1:0]     ld_a  [DEPTH];
    logic [W-1:0]     ld_b  [DEPTH];
    logic [W-1:0]     ld_f  [DEPTH];
    sos_mode_e        ld_m  [DEPTH];

    sos_mode_e        mode_p0;
    logic [W-1:0]     f_p0;
    logic             accept;
    logic             xfer;

    // Stage 0 input: function evaluated in the accepting cycle
    assign mode_p0 = sos_mode_e'(in_mode);
    assign f_p0    = W'(sos_eval(mode_p0, SOS_MAX_W'(Ai), SOS_MAX_W'(Bi), SOS_MAX_W'(Ci)));

    assign in_ready = reset && !flush && adv[0];
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    assign ld_vld[0] = accept;
    assign ld_a[0]   = Ai;
    assign ld_b[0]   = Bi;
    assign ld_f[0]   = f_p0;
    assign ld_m[0]   = mode_p0;

    // Stages 0..DEPTH-1: a stage moves unless it and every stage after it are
    // full while the output is stalled, which collapses bubbles in one cycle.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign adv[i] = out_ready || !(&vld_s[DEPTH-1:i]);

        if (i > 0) begin : g_link
            assign ld_vld[i] = vld_s[i-1];
            assign ld_a[i]   = a_s[i-1];
            assign ld_b[i]   = b_s[i-1];
            assign ld_f[i]   = f_s[i-1];
            assign ld_m[i]   = m_s[i-1];
        end

        sos_stage #(
            .W (W)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .adv        (adv[i]),
            .load_valid (ld_vld[i]),
            .load_a     (ld_a[i]),
            .load_b     (ld_b[i]),
            .load_f     (ld_f[i]),
            .load_mode  (ld_m[i]),
            .valid      (vld_s[i]),
            .a          (a_s[i]),
            .b          (b_s[i]),
            .f          (f_s[i]),
            .mode       (m_s[i])
        );
    end

    // Output stage DEPTH-1
    assign out_valid = vld_s[DEPTH-1];
    assign Ao        = a_s[DEPTH-1];
    assign Bo        = b_s[DEPTH-1];
    assign Fo        = f_s[DEPTH-1];
    assign Mo        = m_s[DEPTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, xfer})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sos_pipe.sv
// Bench for sos_pipe (W=4, DEPTH=2): directed vectors with literal expectations
// plus a queue model checked every cycle, then a random valid/ready stress run.
module tb_sos_pipe;

    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int N_STRESS = 10000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'd0;
    logic [W-1:0]  Ai = '0, Bi = '0, Ci = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Ao, Bo, Fo;
    logic [1:0]    Mo;
    logic [CW-1:0] count;

    sos_pipe #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .Ai        (Ai),
        .Bi        (Bi),
        .Ci        (Ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ao        (Ao),
        .Bo        (Bo),
        .Fo        (Fo),
        .Mo        (Mo),
        .count     (count)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Functions restated per bit: CH is a mux on a, MAJ is a 2-of-3 vote.
    function automatic logic [W-1:0] ref_f(input logic [1:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'd0:    r[i] = (a[i] != b[i]) && c[i];
                2'd1:    r[i] = a[i] ? b[i] : c[i];
                2'd2:    r[i] = ({1'b0, a[i]} + {1'b0, b[i]} + {1'b0, c[i]}) >= 2'd2;
                default: r[i] = a[i] ^ b[i] ^ c[i];
            endcase
        end
        return r;
    endfunction

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic [1:0]   m;
        int           t;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   peak = 0;

    logic         snap_ok = 1'b0;
    logic         s_acc, s_xfer, s_flush;
    logic [W-1:0] s_a, s_b, s_c;
    logic [1:0]   s_m;

    // Compare process: outputs checked against the queue model at every negedge.
    always @(negedge clk) begin
        logic exp_ov;
        if (reset) begin
            exp_ov = (q.size() > 0) && (cyc - q[0].t >= DEPTH - 1);
            chk("in_ready", 32'(in_ready), 32'(!flush && (q.size() < DEPTH || out_ready)));
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && exp_ov) begin
                chk("Ao", 32'(Ao), 32'(q[0].a));
                chk("Bo", 32'(Bo), 32'(q[0].b));
                chk("Fo", 32'(Fo), 32'(q[0].f));
                chk("Mo", 32'(Mo), 32'(q[0].m));
            end
            if (int'(count) > peak) peak = int'(count);
            s_acc   = in_valid && in_ready;
            s_xfer  = out_valid && out_ready;
            s_flush = flush;
            s_a = Ai; s_b = Bi; s_c = Ci; s_m = in_mode;
            snap_ok = 1'b1;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            snap_ok = 1'b0;
        end else if (snap_ok) begin
            if (s_xfer && q.size() > 0) void'(q.pop_front());
            if (s_flush) begin
                q.delete();
            end else if (s_acc) begin
                q.push_back('{a: s_a, b: s_b, f: ref_f(s_m, s_a, s_b, s_c), m: s_m, t: cyc});
                n_acc++;
            end
            snap_ok = 1'b0;
        end
    end

    task automatic offer(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        in_valid = v; in_mode = m; Ai = a; Bi = b; Ci = c;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    initial begin
        int guard;
        // Model pinned against hand-computed values
        chk("model xor_and", 32'(ref_f(2'd0, 4'h3, 4'h6, 4'h1)), 32'h1);
        chk("model ch", 32'(ref_f(2'd1, 4'hC, 4'hA, 4'h6)), 32'hA);
        chk("model maj", 32'(ref_f(2'd2, 4'hC, 4'hA, 4'h6)), 32'hE);
        chk("model parity", 32'(ref_f(2'd3, 4'hC, 4'hA, 4'h6)), 32'h0);

        #1 reset = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst count", 32'(count), 32'h0);
        chk("rst Ao", 32'(Ao), 32'h0);
        chk("rst Fo", 32'(Fo), 32'h0);
        chk("rst Mo", 32'(Mo), 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 32'h1);
        chk("post-rst count", 32'(count), 32'h0);

        // Single triple, XOR_AND, latency DEPTH
        next_cycle();
        out_ready = 1'b1;
        offer(1'b1, 2'd0, 4'h3, 4'h6, 4'h1);
        next_cycle();
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t1 early out_valid", 32'(out_valid), 32'h0);
        chk("t1 count", 32'(count), 32'h1);
        @(negedge clk);
        chk("t1 out_valid", 32'(out_valid), 32'h1);
        chk("t1 Ao", 32'(Ao), 32'h3);
        chk("t1 Bo", 32'(Bo), 32'h6);
        chk("t1 Fo", 32'(Fo), 32'h1);
        chk("t1 Mo", 32'(Mo), 32'h0);

        // Back-to-back CH, MAJ, PARITY on one triple
        next_cycle();
        peak = 0;
        offer(1'b1, 2'd1, 4'hC, 4'hA, 4'h6);
        next_cycle();
        offer(1'b1, 2'd2, 4'hC, 4'hA, 4'h6);
        next_cycle();
        offer(1'b1, 2'd3, 4'hC, 4'hA, 4'h6);
        @(negedge clk);
        chk("t2 Fo ch", 32'(Fo), 32'hA);
        chk("t2 Mo ch", 32'(Mo), 32'h1);
        next_cycle();
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t2 Fo maj", 32'(Fo), 32'hE);
        chk("t2 Mo maj", 32'(Mo), 32'h2);
        @(negedge clk);
        chk("t2 out_valid parity", 32'(out_valid), 32'h1);
        chk("t2 Fo parity", 32'(Fo), 32'h0);
        chk("t2 Mo parity", 32'(Mo), 32'h3);
        chk("t2 count peak", 32'(peak), 32'h2);

        // Back-pressure: full pipe holds, release accepts and delivers together
        next_cycle();
        out_ready = 1'b0;
        offer(1'b1, 2'd3, 4'h1, 4'h2, 4'h4);
        next_cycle();
        offer(1'b1, 2'd1, 4'h5, 4'hF, 4'hA);
        next_cycle();
        offer(1'b1, 2'd0, 4'h7, 4'h9, 4'hE);
        @(negedge clk);
        chk("t3 full in_ready", 32'(in_ready), 32'h0);
        chk("t3 full count", 32'(count), 32'h2);
        chk("t3 full Ao", 32'(Ao), 32'h1);
        chk("t3 full Fo", 32'(Fo), 32'h7);
        @(negedge clk);
        chk("t3 held Ao", 32'(Ao), 32'h1);
        chk("t3 held Fo", 32'(Fo), 32'h7);
        chk("t3 held Mo", 32'(Mo), 32'h3);
        chk("t3 held count", 32'(count), 32'h2);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3 release in_ready", 32'(in_ready), 32'h1);
        next_cycle();
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t3 swap count", 32'(count), 32'h2);
        chk("t3 second Ao", 32'(Ao), 32'h5);
        chk("t3 second Fo", 32'(Fo), 32'hF);
        @(negedge clk);
        chk("t3 third Ao", 32'(Ao), 32'h7);
        chk("t3 third Fo", 32'(Fo), 32'hE);
        chk("t3 drain count", 32'(count), 32'h1);

        // Flush with a full pipe and a pending input
        next_cycle();
        out_ready = 1'b0;
        offer(1'b1, 2'd3, 4'h8, 4'h4, 4'h2);
        next_cycle();
        offer(1'b1, 2'd2, 4'h2, 4'h3, 4'h1);
        next_cycle();
        flush = 1'b1;
        offer(1'b1, 2'd3, 4'h9, 4'h9, 4'h9);
        @(negedge clk);
        chk("t4 flush in_ready", 32'(in_ready), 32'h0);
        chk("t4 pre-flush count", 32'(count), 32'h2);
        chk("t4 pre-flush Fo", 32'(Fo), 32'hE);
        next_cycle();
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t4 flushed count", 32'(count), 32'h0);
        chk("t4 flushed out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4 stays empty", 32'(out_valid), 32'h0);
        end

        // Asynchronous reset mid-stream
        next_cycle();
        offer(1'b1, 2'd0, 4'h6, 4'h5, 4'h3);
        next_cycle();
        offer(1'b1, 2'd3, 4'hA, 4'h5, 4'hF);
        next_cycle();
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        chk("t5 pre-rst out_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b0;
        q.delete();
        snap_ok = 1'b0;
        #1;
        chk("t5 rst out_valid", 32'(out_valid), 32'h0);
        chk("t5 rst count", 32'(count), 32'h0);
        chk("t5 rst Fo", 32'(Fo), 32'h0);
        chk("t5 rst in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        next_cycle();
        offer(1'b1, 2'd2, 4'hB, 4'hD, 4'h7);
        next_cycle();
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t5 early out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("t5 out_valid", 32'(out_valid), 32'h1);
        chk("t5 Fo", 32'(Fo), 32'hF);
        chk("t5 Mo", 32'(Mo), 32'h2);

        // Random valid/ready stress with rare flushes
        n_acc = 0;
        guard = 0;
        while (n_acc < N_STRESS && guard < 60000) begin
            next_cycle();
            guard++;
            offer($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 999) == 0;
        end
        chk("stress budget", 32'(n_acc >= N_STRESS), 32'h1);
        next_cycle();
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        guard = 0;
        while ((q.size() > 0 || out_valid) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain model empty", 32'(q.size()), 32'h0);
        chk("drain out_valid", 32'(out_valid), 32'h0);
        chk("drain count", 32'(count), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
